// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave front end for the UART register block.
// AW, W and AR are each held in a one-entry buffer. A small FSM turns every
// accepted write or read into a single-cycle strobe on the register bus and
// returns the write response on B or the read data on R.
module axi4_lite_reg_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   awaddr_in,
  input  logic [2:0]              awprot_in,
  input  logic                    awvalid_in,
  output logic                    awready_out,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [DATA_WIDTH/8-1:0] wstrb_in,
  input  logic                    wvalid_in,
  output logic                    wready_out,
  // write response channel
  output logic [1:0]              bresp_out,
  output logic                    bvalid_out,
  input  logic                    bready_in,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   araddr_in,
  input  logic [2:0]              arprot_in,
  input  logic                    arvalid_in,
  output logic                    arready_out,
  // read data channel
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic [1:0]              rresp_out,
  output logic                    rvalid_out,
  input  logic                    rready_in,
  // register bus
  output logic [1:0]              reg_addr,
  output logic                    reg_we,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  output logic                    reg_re,
  input  logic [DATA_WIDTH-1:0]   reg_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WSTB  = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RSTB  = 3'd3;
  localparam logic [2:0] S_RCAP  = 3'd4;
  localparam logic [2:0] S_RRESP = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address decodes cleanly only inside the 16-byte register window and
  // onto an implemented word; the byte offset bits are ignored.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:4] != '0) || (int'(a[3:2]) >= NUM_REGS);
  endfunction

  // input buffers
  logic                  aw_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  ar_full_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;

  // control
  logic [2:0]            state_q, state_d;
  logic                  last_rd_q;

  // registered outputs
  logic [1:0]            reg_addr_q;
  logic [DATA_WIDTH-1:0] reg_wdata_q;
  logic [STRB_WIDTH-1:0] reg_wstrb_q;
  logic                  reg_we_q;
  logic                  reg_re_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic idle;
  logic wr_ready, rd_ready;
  logic grant_wr, grant_rd;
  logic aw_err, ar_err;
  logic b_hs, r_hs;

  // Protection attributes and the byte offset are deliberately not used.
  logic unused_ok;
  assign unused_ok = ^{awprot_in, arprot_in, aw_addr_q[1:0], ar_addr_q[1:0]};

  assign idle     = (state_q == S_IDLE);
  assign wr_ready = aw_full_q & w_full_q;
  assign rd_ready = ar_full_q;

  // On a tie the side opposite to the previous tie winner goes first.
  assign grant_wr = idle & wr_ready & (~rd_ready | last_rd_q);
  assign grant_rd = idle & rd_ready & (~wr_ready | ~last_rd_q);

  assign aw_err = addr_err(aw_addr_q);
  assign ar_err = addr_err(ar_addr_q);

  assign b_hs = (state_q == S_WRESP) & bready_in;
  assign r_hs = (state_q == S_RRESP) & rready_in;

  assign awready_out = ~aw_full_q;
  assign wready_out  = ~w_full_q;
  assign arready_out = ~ar_full_q;

  assign bvalid_out = (state_q == S_WRESP);
  assign bresp_out  = bresp_q;
  assign rvalid_out = (state_q == S_RRESP);
  assign rresp_out  = rresp_q;
  assign rdata_out  = rdata_q;

  assign reg_addr  = reg_addr_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wstrb = reg_wstrb_q;
  assign reg_re    = reg_re_q;

  // Write address buffer: fills on handshake, empties on the B handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
    end else if (b_hs) begin
      aw_full_q <= 1'b0;
    end else if (awvalid_in && !aw_full_q) begin
      aw_full_q <= 1'b1;
      aw_addr_q <= awaddr_in;
    end
  end

  // Write data buffer: fills on handshake, empties on the B handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (b_hs) begin
      w_full_q <= 1'b0;
    end else if (wvalid_in && !w_full_q) begin
      w_full_q <= 1'b1;
      w_data_q <= wdata_in;
      w_strb_q <= wstrb_in;
    end
  end

  // Read address buffer: fills on handshake, empties on the R handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
    end else if (r_hs) begin
      ar_full_q <= 1'b0;
    end else if (arvalid_in && !ar_full_q) begin
      ar_full_q <= 1'b1;
      ar_addr_q <= araddr_in;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          state_d = S_WSTB;
        end else if (grant_rd) begin
          state_d = S_RSTB;
        end
      end
      S_WSTB:  state_d = S_WRESP;
      S_WRESP: if (bready_in) state_d = S_IDLE;
      S_RSTB:  state_d = S_RCAP;
      S_RCAP:  state_d = S_RRESP;
      S_RRESP: if (rready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and tie-break memory (resets to "read" so the first
  // contended grant goes to the write side; only ties update it).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      last_rd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (idle && wr_ready && rd_ready) begin
        last_rd_q <= grant_rd;
      end
    end
  end

  // Register-bus strobes are registered at grant time so they are high for
  // exactly the WSTB/RSTB cycle; address and data hold afterwards.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      reg_we_q <= grant_wr & ~aw_err;
      reg_re_q <= grant_rd & ~ar_err;
      if (grant_wr) begin
        reg_addr_q  <= aw_addr_q[3:2];
        reg_wdata_q <= w_data_q;
        reg_wstrb_q <= w_strb_q;
      end else if (grant_rd) begin
        reg_addr_q  <= ar_addr_q[3:2];
      end
    end
  end

  // Response capture: B status after the write strobe, R data/status in RCAP.
  // Both hold until the next transaction of the same kind.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      if (state_q == S_WSTB) begin
        bresp_q <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == S_RCAP) begin
        rresp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= ar_err ? '0 : reg_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Self-checking bench for axi4_lite_reg_bridge: expectations are queued when
// a transaction is issued and compared when the DUT strobes and responds.
module tb_axi4_lite_reg_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr_in = '0;
  logic [2:0]  awprot_in = '0;
  logic        awvalid_in = 1'b0;
  logic        awready_out;
  logic [31:0] wdata_in = '0;
  logic [3:0]  wstrb_in = '0;
  logic        wvalid_in = 1'b0;
  logic        wready_out;
  logic [1:0]  bresp_out;
  logic        bvalid_out;
  logic        bready_in = 1'b0;
  logic [31:0] araddr_in = '0;
  logic [2:0]  arprot_in = '0;
  logic        arvalid_in = 1'b0;
  logic        arready_out;
  logic [31:0] rdata_out;
  logic [1:0]  rresp_out;
  logic        rvalid_out;
  logic        rready_in = 1'b0;
  logic [1:0]  reg_addr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_re;
  logic [31:0] reg_rdata;

  axi4_lite_reg_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (4)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .awaddr_in  (awaddr_in),
    .awprot_in  (awprot_in),
    .awvalid_in (awvalid_in),
    .awready_out(awready_out),
    .wdata_in   (wdata_in),
    .wstrb_in   (wstrb_in),
    .wvalid_in  (wvalid_in),
    .wready_out (wready_out),
    .bresp_out  (bresp_out),
    .bvalid_out (bvalid_out),
    .bready_in  (bready_in),
    .araddr_in  (araddr_in),
    .arprot_in  (arprot_in),
    .arvalid_in (arvalid_in),
    .arready_out(arready_out),
    .rdata_out  (rdata_out),
    .rresp_out  (rresp_out),
    .rvalid_out (rvalid_out),
    .rready_in  (rready_in),
    .reg_addr   (reg_addr),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Register-file model: data is presented only in the cycle after reg_re,
  // junk otherwise, so a mistimed capture shows up as wrong rdata.
  logic [31:0] model [4];
  logic        rd_phase = 1'b0;
  logic [1:0]  rd_idx = '0;
  always @(posedge aclk) begin
    rd_phase <= reg_re;
    rd_idx   <= reg_addr;
  end
  assign reg_rdata = rd_phase ? model[rd_idx] : 32'hDEAD_BEEF;

  int n_vec = 0;
  int n_err = 0;
  int last_done = 0;

  typedef struct {
    logic [1:0]  idx;
    logic        ok;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.idx  = a[3:2];
    e.ok   = (a[31:4] == 28'h0);
    e.data = d;
    e.strb = s;
    wq.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] a);
    exp_t e;
    e.idx  = a[3:2];
    e.ok   = (a[31:4] == 28'h0);
    e.data = e.ok ? model[a[3:2]] : 32'h0;
    e.strb = 4'h0;
    rq.push_back(e);
  endtask

  // Present the selected channels together; acc = cycle after the last accept edge.
  task automatic drive(input bit do_aw, input bit do_w, input bit do_ar,
                       input logic [31:0] aa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] ra, output int acc);
    bit pa, pw, pr, ta, tw, tr;
    int n;
    pa = do_aw; pw = do_w; pr = do_ar; n = 0;
    awaddr_in = aa; wdata_in = wd; wstrb_in = ws; araddr_in = ra;
    awvalid_in = pa; wvalid_in = pw; arvalid_in = pr;
    while ((pa || pw || pr) && n < 40) begin
      ta = pa && awready_out;
      tw = pw && wready_out;
      tr = pr && arready_out;
      step();
      n++;
      if (ta) begin pa = 0; awvalid_in = 1'b0; end
      if (tw) begin pw = 0; wvalid_in = 1'b0; end
      if (tr) begin pr = 0; arvalid_in = 1'b0; end
    end
    acc = cyc;
    awvalid_in = 1'b0; wvalid_in = 1'b0; arvalid_in = 1'b0;
    n_vec++;
    if (pa || pw || pr) begin
      n_err++;
      $display("FAIL accept_timeout got aw/w/ar pending=%b%b%b want=000", pa, pw, pr);
    end
  endtask

  // Pop one write expectation; strobe must appear at cycle s, B at s+1.
  task automatic collect_write(input int s, input int hold, input bit chk_ar);
    exp_t e;
    int n;
    if (wq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL wq_empty got=0 entries want>=1");
      return;
    end
    e = wq.pop_front();
    n = 0;
    while (cyc < s && n < 60) begin step(); n++; end
    n_vec++;
    if (cyc != s) begin n_err++; $display("FAIL wr_strobe_cycle got=%0d want=%0d", cyc, s); end
    n_vec++;
    if (reg_we !== e.ok) begin n_err++; $display("FAIL reg_we got=%b want=%b", reg_we, e.ok); end
    n_vec++;
    if (reg_addr !== e.idx) begin n_err++; $display("FAIL wr_reg_addr got=%0d want=%0d", reg_addr, e.idx); end
    if (e.ok) begin
      n_vec++;
      if (reg_wdata !== e.data || reg_wstrb !== e.strb) begin
        n_err++;
        $display("FAIL reg_wdata_strb got=%h/%h want=%h/%h", reg_wdata, reg_wstrb, e.data, e.strb);
      end
    end
    step();
    n_vec++;
    if (bvalid_out !== 1'b1 || bresp_out !== (e.ok ? 2'b00 : 2'b10) || reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL bresp got=v%b r%b we%b want=v1 r%b we0", bvalid_out, bresp_out, reg_we,
               e.ok ? 2'b00 : 2'b10);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      n_vec++;
      if (bvalid_out !== 1'b1 || bresp_out !== (e.ok ? 2'b00 : 2'b10) || reg_re !== 1'b0 ||
          awready_out !== 1'b0 || wready_out !== 1'b0 || (chk_ar && arready_out !== 1'b0)) begin
        n_err++;
        $display("FAIL b_hold got=v%b r%b re%b rdy%b%b%b want=v1 r%b re0 rdy00%b", bvalid_out,
                 bresp_out, reg_re, awready_out, wready_out, arready_out,
                 e.ok ? 2'b00 : 2'b10, !chk_ar);
      end
    end
    bready_in = 1'b1;
    step();
    bready_in = 1'b0;
    n_vec++;
    if (bvalid_out !== 1'b0 || awready_out !== 1'b1 || wready_out !== 1'b1) begin
      n_err++;
      $display("FAIL b_done got=v%b rdy%b%b want=v0 rdy11", bvalid_out, awready_out, wready_out);
    end
    last_done = cyc;
  endtask

  // Pop one read expectation; strobe at s, nothing at s+1, R at s+2.
  task automatic collect_read(input int s, input int hold);
    exp_t e;
    int n;
    if (rq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL rq_empty got=0 entries want>=1");
      return;
    end
    e = rq.pop_front();
    n = 0;
    while (cyc < s && n < 60) begin step(); n++; end
    n_vec++;
    if (cyc != s) begin n_err++; $display("FAIL rd_strobe_cycle got=%0d want=%0d", cyc, s); end
    n_vec++;
    if (reg_re !== e.ok || reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL reg_re got=re%b we%b want=re%b we0", reg_re, reg_we, e.ok);
    end
    n_vec++;
    if (reg_addr !== e.idx) begin n_err++; $display("FAIL rd_reg_addr got=%0d want=%0d", reg_addr, e.idx); end
    step();
    n_vec++;
    if (rvalid_out !== 1'b0 || reg_re !== 1'b0) begin
      n_err++;
      $display("FAIL rcap got=v%b re%b want=v0 re0", rvalid_out, reg_re);
    end
    step();
    for (int i = 0; i <= hold; i++) begin
      n_vec++;
      if (rvalid_out !== 1'b1 || rdata_out !== e.data || rresp_out !== (e.ok ? 2'b00 : 2'b10)) begin
        n_err++;
        $display("FAIL rresp got=v%b d%h r%b want=v1 d%h r%b", rvalid_out, rdata_out, rresp_out,
                 e.data, e.ok ? 2'b00 : 2'b10);
      end
      if (i < hold) step();
    end
    rready_in = 1'b1;
    step();
    rready_in = 1'b0;
    n_vec++;
    if (rvalid_out !== 1'b0 || arready_out !== 1'b1) begin
      n_err++;
      $display("FAIL r_done got=v%b ardy%b want=v0 ardy1", rvalid_out, arready_out);
    end
    last_done = cyc;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({awready_out, wready_out, arready_out, bvalid_out, rvalid_out, reg_we, reg_re} !== 7'b1110000) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b want=1110000",
               {awready_out, wready_out, arready_out, bvalid_out, rvalid_out, reg_we, reg_re});
    end
    n_vec++;
    if ({bresp_out, rresp_out, rdata_out, reg_addr, reg_wdata, reg_wstrb} !== 74'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0",
               {bresp_out, rresp_out, rdata_out, reg_addr, reg_wdata, reg_wstrb});
    end
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_simple_write();
    int acc;
    push_w(32'h4, 32'hA5, 4'hF);
    drive(1, 1, 0, 32'h4, 32'hA5, 4'hF, 32'h0, acc);
    collect_write(acc + 1, 0, 0);
    push_w(32'h7, 32'hDEAD_0001, 4'h3);
    drive(1, 1, 0, 32'h7, 32'hDEAD_0001, 4'h3, 32'h0, acc);
    collect_write(acc + 1, 0, 0);
  endtask

  task automatic test_reordered_write();
    int acc;
    push_w(32'h8, 32'h5A5A_0F0F, 4'hC);
    drive(0, 1, 0, 32'h0, 32'h5A5A_0F0F, 4'hC, 32'h0, acc);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (wready_out !== 1'b0 || reg_we !== 1'b0 || awready_out !== 1'b1) begin
        n_err++;
        $display("FAIL w_only got=wrdy%b we%b awrdy%b want=wrdy0 we0 awrdy1", wready_out, reg_we, awready_out);
      end
      step();
    end
    drive(1, 0, 0, 32'h8, 32'h5A5A_0F0F, 4'hC, 32'h0, acc);
    collect_write(acc + 1, 0, 0);
  endtask

  task automatic test_read();
    int acc;
    model[3] = 32'h1234_5678;
    model[1] = 32'h0BEE_F001;
    push_r(32'hC);
    drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'hC, acc);
    collect_read(acc + 1, 0);
    push_r(32'h4);
    drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h4, acc);
    collect_read(acc + 1, 2);
  endtask

  task automatic test_decode_error();
    int acc;
    push_w(32'h10, 32'h1111_2222, 4'hF);
    drive(1, 1, 0, 32'h10, 32'h1111_2222, 4'hF, 32'h0, acc);
    collect_write(acc + 1, 0, 0);
    push_r(32'h40);
    drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40, acc);
    collect_read(acc + 1, 0);
  endtask

  task automatic test_arbitration();
    int acc;
    do_reset();
    model[2] = 32'hCAFE_0002;
    model[0] = 32'h0000_00A0;
    push_w(32'h0, 32'h7777_0000, 4'hF);
    push_r(32'h8);
    drive(1, 1, 1, 32'h0, 32'h7777_0000, 4'hF, 32'h8, acc);
    collect_write(acc + 1, 0, 0);
    collect_read(last_done + 1, 0);
    push_r(32'h0);
    push_w(32'h4, 32'h8888_0001, 4'h5);
    drive(1, 1, 1, 32'h4, 32'h8888_0001, 4'h5, 32'h0, acc);
    collect_read(acc + 1, 0);
    collect_write(last_done + 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int acc;
    push_w(32'hC, 32'h0123_4567, 4'h9);
    push_r(32'h0);
    drive(1, 1, 1, 32'hC, 32'h0123_4567, 4'h9, 32'h0, acc);
    collect_write(acc + 1, 5, 1);
    collect_read(last_done + 1, 0);
  endtask

  task automatic test_reset_midop();
    int acc;
    model[0] = 32'h0BAD_F00D;
    drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, acc);
    step(); step(); step();
    n_vec++;
    if (rvalid_out !== 1'b1 || rdata_out !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL midop_rresp got=v%b d%h want=v1 d0bad_f00d", rvalid_out, rdata_out);
    end
    aresetn = 1'b0;
    #1;
    n_vec++;
    if ({awready_out, wready_out, arready_out, bvalid_out, rvalid_out, reg_we, reg_re} !== 7'b1110000) begin
      n_err++;
      $display("FAIL midop_reset_ctrl got=%b want=1110000",
               {awready_out, wready_out, arready_out, bvalid_out, rvalid_out, reg_we, reg_re});
    end
    n_vec++;
    if ({rdata_out, rresp_out, bresp_out} !== 36'h0) begin
      n_err++;
      $display("FAIL midop_reset_data got=%h want=0", {rdata_out, rresp_out, bresp_out});
    end
    step();
    aresetn = 1'b1;
    step();
    n_vec++;
    if ({awready_out, wready_out, arready_out, bvalid_out, rvalid_out} !== 5'b11100) begin
      n_err++;
      $display("FAIL midop_release got=%b want=11100",
               {awready_out, wready_out, arready_out, bvalid_out, rvalid_out});
    end
    push_w(32'hC, 32'hFACE_0C0C, 4'hF);
    drive(1, 1, 0, 32'hC, 32'hFACE_0C0C, 4'hF, 32'h0, acc);
    collect_write(acc + 1, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    test_reset();
    test_simple_write();
    test_reordered_write();
    test_read();
    test_decode_error();
    test_arbitration();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
